vga_scanout: RTL and testbench
==============================

Name: vga_scanout

Overview:
- Display-side consumer of the 15-bit RGB555 frame buffer.
- Generates 640x480@60 VGA timing and issues frame-buffer read requests using the {y,x} address format (`rd_addr = {y[9:0], x[9:0]}`).
- Realigns sync and data-enable signals to the buffer's read latency.
- Splits each pixel into 5-bit R/G/B channels and blanks output until the buffer reports a complete frame.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- RD_LATENCY, 1, clk cycles from rd_en to valid rd_data (1..4)
- SYNC_POL, 0, asserted level of hsync/vsync

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- en  input  1  pixel tick; timing advances only when high
- frame_valid  input  1  frame buffer holds a complete frame
- rd_data  input  15  pixel from buffer, {R[14:10],G[9:5],B[4:0]}
- rd_en  output  1  read request, one per active pixel tick
- rd_addr  output  20  {v_cnt[9:0], h_cnt[9:0]}
- vga_r  output  5  red
- vga_g  output  5  green
- vga_b  output  5  blue
- hsync  output  1  horizontal sync
- vsync  output  1  vertical sync
- de  output  1  active-video qualifier aligned with vga_r/g/b
- frame_start  output  1  one-clk pulse at first pixel of each frame

Behaviour:
- Reset (rst=0, asynchronous):
  - h_cnt=0, v_cnt=0, state=WAIT, all pipeline taps cleared.
  - rd_en=0, rd_addr=0, vga_r/g/b=0, de=0, frame_start=0.
  - hsync=vsync=~SYNC_POL (deasserted).
- Counters:
  - H_TOTAL=800, V_TOTAL=525.
  - On clk with en=1: h_cnt increments; at h_cnt=H_TOTAL-1 it wraps to 0 and v_cnt increments.
  - v_cnt wraps to 0 after V_TOTAL-1 on the same tick.
  - en=0 holds both counters.
- Stage 0 (combinational from counters, qualified by en):
  - active = (h_cnt<H_ACTIVE) && (v_cnt<V_ACTIVE).
  - hs0 asserted for h_cnt in [656,751]; vs0 asserted for v_cnt in [490,491].
  - rd_en = en && active && (state==DISPLAY).
  - rd_addr = {v_cnt,h_cnt}, registered 0 when rd_en=0.
  - frame_start = en && h_cnt==0 && v_cnt==0, independent of state.
- Alignment pipeline:
  - {en, active&&DISPLAY, hs0, vs0} pass through an RD_LATENCY-deep shift register that advances every clk.
  - Output register loads on clk when the delayed en tap is 1; otherwise it holds.
  - Loaded values: de = delayed active; vga_r/g/b = rd_data fields when delayed active, else 0; hsync/vsync = delayed sync at SYNC_POL.
  - Latency: counter state to pins = RD_LATENCY+1 clk.
- State machine:
  - WAIT: syncs run, de=0, rgb=0, no reads.
  - WAIT -> ARMED when frame_valid=1.
  - ARMED -> DISPLAY on the frame_start tick.
  - ARMED -> WAIT if frame_valid drops before that tick.
  - DISPLAY -> WAIT on the last tick of a frame (h=799, v=524, en=1) if frame_valid=0; a mid-frame drop never truncates a frame.
- Boundaries:
  - Simultaneous h and v wrap occur in one clk.
  - Reset mid-frame: syncs deassert immediately; restart at (0,0) in WAIT.
  - rd_data is ignored whenever the delayed active tap is 0.

Test Plan:
- Reset with en=1 for 2x420000 clk, frame_valid=0 -> hsync low for 96 of every 800 ticks, starting 657+RD_LATENCY clk after reset release; vsync low for 1600 ticks per frame; de=0, rd_en=0 throughout.
- Raise frame_valid mid-frame -> no rd_en until the next frame_start; then exactly 307200 rd_en pulses per frame, first rd_addr=0x00000, last rd_addr=0x77E7F.
- rd_data model returning rd_addr[14:0] with RD_LATENCY=1 and 3 -> at pixel (x=5,y=2), vga_r/g/b=rd_data[14:10]/[9:5]/[4:0]; de rises exactly RD_LATENCY+1 clk after first rd_en.
- en toggling 1/0 each clk -> counters advance every other clk; line length 1600 clk; output values hold during en=0 cycles.
- Drop frame_valid at pixel (100,100) -> current frame completes with de active; next frame de=0 and rgb=0.
- Assert rst at (300,200) -> all outputs reset within the same cycle; after release the first frame_start occurs 1 clk after the first en tick.

Source files
------------

// File: rtl/vga_scanout.sv
`default_nettype none
// ============================================================================
// Module   : vga_scanout
// Function : VGA timing generator and RGB555 frame-buffer scanout with sync
//            realignment to the buffer read latency.
// Revision : 1.0 - initial release
// ============================================================================
module vga_scanout #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int RD_LATENCY = 1,
  parameter bit SYNC_POL   = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        frame_valid,
  input  logic [14:0] rd_data,
  output logic        rd_en,
  output logic [19:0] rd_addr,
  output logic [4:0]  vga_r,
  output logic [4:0]  vga_g,
  output logic [4:0]  vga_b,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        frame_start
);

  localparam logic [9:0] c_H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] c_HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] c_HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] c_H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] c_V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] c_VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] c_VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] c_V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam int         c_PW     = 4 * RD_LATENCY;

  typedef enum logic [1:0] {
    ST_WAIT    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_DISPLAY = 2'd2
  } state_t;

  state_t          r_state;
  logic [9:0]      r_h_cnt;
  logic [9:0]      r_v_cnt;
  logic            r_frame_start;
  logic [c_PW-1:0] r_pipe;
  logic            r_de;
  logic            r_hsync;
  logic            r_vsync;
  logic [4:0]      r_r;
  logic [4:0]      r_g;
  logic [4:0]      r_b;

  logic       w_h_last;
  logic       w_v_last;
  logic       w_frame_end;
  logic       w_first;
  logic       w_active;
  logic       w_display;
  logic       w_hs0;
  logic       w_vs0;
  logic [3:0] w_stage0;
  logic       w_tap_en;
  logic       w_tap_act;
  logic       w_tap_hs;
  logic       w_tap_vs;

  assign w_h_last    = (r_h_cnt == c_H_LAST);
  assign w_v_last    = (r_v_cnt == c_V_LAST);
  assign w_frame_end = en && w_h_last && w_v_last;
  assign w_first     = (r_h_cnt == 10'd0) && (r_v_cnt == 10'd0);
  assign w_active    = (r_h_cnt < c_H_ACT) && (r_v_cnt < c_V_ACT);
  assign w_display   = (r_state == ST_DISPLAY);
  assign w_hs0       = (r_h_cnt >= c_HS_BEG) && (r_h_cnt <= c_HS_END);
  assign w_vs0       = (r_v_cnt >= c_VS_BEG) && (r_v_cnt <= c_VS_END);
  assign w_stage0    = {en, w_active && w_display, w_hs0, w_vs0};

  assign rd_en   = en && w_active && w_display;
  assign rd_addr = rd_en ? {r_v_cnt, r_h_cnt} : 20'd0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_h_cnt <= 10'd0;
      r_v_cnt <= 10'd0;
    end else if (en) begin
      if (w_h_last) begin
        r_h_cnt <= 10'd0;
        r_v_cnt <= w_v_last ? 10'd0 : r_v_cnt + 10'd1;
      end else begin
        r_h_cnt <= r_h_cnt + 10'd1;
      end
    end
  end

  // Arming commits on the frame-end tick so reads start exactly at pixel (0,0).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_WAIT;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= en && w_first;
      case (r_state)
        ST_WAIT: begin
          if (frame_valid) r_state <= ST_ARMED;
        end
        ST_ARMED: begin
          if (!frame_valid)     r_state <= ST_WAIT;
          else if (w_frame_end) r_state <= ST_DISPLAY;
        end
        ST_DISPLAY: begin
          if (w_frame_end && !frame_valid) r_state <= ST_WAIT;
        end
        default: r_state <= ST_WAIT;
      endcase
    end
  end

  if (RD_LATENCY == 1) begin : g_pipe_one
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_pipe <= '0;
      else      r_pipe <= w_stage0;
    end
  end else begin : g_pipe_deep
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_pipe <= '0;
      else      r_pipe <= {r_pipe[c_PW-5:0], w_stage0};
    end
  end

  assign {w_tap_en, w_tap_act, w_tap_hs, w_tap_vs} = r_pipe[c_PW-1 -: 4];

  // Output stage only moves on delayed pixel ticks, so pins hold while en is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_de    <= 1'b0;
      r_r     <= 5'd0;
      r_g     <= 5'd0;
      r_b     <= 5'd0;
      r_hsync <= ~SYNC_POL;
      r_vsync <= ~SYNC_POL;
    end else if (w_tap_en) begin
      r_de    <= w_tap_act;
      r_r     <= w_tap_act ? rd_data[14:10] : 5'd0;
      r_g     <= w_tap_act ? rd_data[9:5]   : 5'd0;
      r_b     <= w_tap_act ? rd_data[4:0]   : 5'd0;
      r_hsync <= w_tap_hs ? SYNC_POL : ~SYNC_POL;
      r_vsync <= w_tap_vs ? SYNC_POL : ~SYNC_POL;
    end
  end

  assign de          = r_de;
  assign vga_r       = r_r;
  assign vga_g       = r_g;
  assign vga_b       = r_b;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_scanout.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_scanout
// Function : Directed self-checking bench for vga_scanout (reduced and full
//            timing, read latencies 1 and 3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_scanout;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic en;
  logic frame_valid;

  logic [14:0] rd_data1, rd_data3, rd_dataf;
  logic        rd_en1, rd_en3, rd_enf;
  logic [19:0] addr1, addr3, addrf;
  logic [4:0]  r1, g1, b1, r3, g3, b3, rf, gf, bf;
  logic        hs1, vs1, de1, fs1, hs3, vs3, de3, fs3, hsf, vsf, def, fsf;

  vga_scanout #(
    .H_ACTIVE(40), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .RD_LATENCY(1), .SYNC_POL(1'b0)
  ) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .frame_valid(frame_valid), .rd_data(rd_data1),
    .rd_en(rd_en1), .rd_addr(addr1), .vga_r(r1), .vga_g(g1), .vga_b(b1),
    .hsync(hs1), .vsync(vs1), .de(de1), .frame_start(fs1)
  );

  vga_scanout #(
    .H_ACTIVE(40), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .RD_LATENCY(3), .SYNC_POL(1'b0)
  ) u_dut3 (
    .clk(clk), .rst(rst), .en(en), .frame_valid(frame_valid), .rd_data(rd_data3),
    .rd_en(rd_en3), .rd_addr(addr3), .vga_r(r3), .vga_g(g3), .vga_b(b3),
    .hsync(hs3), .vsync(vs3), .de(de3), .frame_start(fs3)
  );

  vga_scanout u_dutf (
    .clk(clk), .rst(rst), .en(en), .frame_valid(frame_valid), .rd_data(rd_dataf),
    .rd_en(rd_enf), .rd_addr(addrf), .vga_r(rf), .vga_g(gf), .vga_b(bf),
    .hsync(hsf), .vsync(vsf), .de(def), .frame_start(fsf)
  );

  // Buffer models: return the low address bits, junk when no read is pending.
  logic [14:0] d3a, d3b;
  always @(posedge clk) rd_data1 <= rd_en1 ? addr1[14:0] : 15'h7FFF;
  always @(posedge clk) begin
    d3a      <= rd_en3 ? addr3[14:0] : 15'h7FFF;
    d3b      <= d3a;
    rd_data3 <= d3b;
  end
  assign rd_dataf = 15'h2AAA;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    cyc = 0;
  endtask

  function automatic logic [39:0] pk(input logic f, input logic re, input logic [19:0] a,
                                     input logic d, input logic [4:0] r, input logic [4:0] g,
                                     input logic [4:0] b, input logic h, input logic v);
    return {f, re, a, d, r, g, b, h, v};
  endfunction

  function automatic logic [39:0] pk1();
    return pk(fs1, rd_en1, addr1, de1, r1, g1, b1, hs1, vs1);
  endfunction

  function automatic logic [39:0] pk3();
    return pk(fs3, rd_en3, addr3, de3, r3, g3, b3, hs3, vs3);
  endfunction

  typedef struct {
    int          cyc;
    logic        en;
    logic        fv;
    logic [39:0] exp;
  } vec_t;

  vec_t vt[$];

  initial begin
    logic [39:0] rst_pk;
    int fall1, fall2, rise1, viol, first_rd, fde1, fde3, fs_bad, mism;
    logic prev;

    rst_pk = pk(1'b0, 1'b0, 20'h0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);

    // Reset values with en and frame_valid both high.
    rst = 1'b0; en = 1'b1; frame_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_dut1", pk1(), rst_pk);
    chk("reset_dut3", pk3(), rst_pk);
    chk("reset_full", {rd_enf, addrf, def, rf, gf, bf, hsf, vsf, fsf},
        {1'b0, 20'h0, 1'b0, 15'h0, 1'b1, 1'b1, 1'b0});

    // Full 640x480 timing: hsync position, width and period.
    frame_valid = 1'b0;
    rst = 1'b1; cyc = 0;
    fall1 = -1; fall2 = -1; rise1 = -1; viol = 0; prev = 1'b1;
    for (int c = 1; c <= 1700; c++) begin
      step();
      if (cyc == 1) chk("full_frame_start", fsf, 1);
      if (prev && !hsf) begin
        if (fall1 < 0) fall1 = cyc;
        else if (fall2 < 0) fall2 = cyc;
      end
      if (!prev && hsf && rise1 < 0) rise1 = cyc;
      if (def || rd_enf || !vsf || addrf != 20'h0 || {rf, gf, bf} != 15'h0) viol++;
      prev = hsf;
    end
    chk("full_hsync_first_fall", fall1, 658);
    chk("full_hsync_width", rise1 - fall1, 96);
    chk("full_hsync_period", fall2 - fall1, 800);
    chk("full_idle_outputs", viol, 0);

    // Reduced timing 48x9 (40x4 active), latency 1: directed vectors.
    vt.push_back('{1,    1'b1, 1'b0, pk(1, 0, 20'h0,   0, 0, 0, 0, 1, 1)});
    vt.push_back('{2,    1'b1, 1'b0, pk(0, 0, 20'h0,   0, 0, 0, 0, 1, 1)});
    vt.push_back('{44,   1'b1, 1'b0, pk(0, 0, 20'h0,   0, 0, 0, 0, 0, 1)});
    vt.push_back('{47,   1'b1, 1'b0, pk(0, 0, 20'h0,   0, 0, 0, 0, 0, 1)});
    vt.push_back('{48,   1'b1, 1'b0, pk(0, 0, 20'h0,   0, 0, 0, 0, 1, 1)});
    vt.push_back('{242,  1'b1, 1'b0, pk(0, 0, 20'h0,   0, 0, 0, 0, 1, 0)});
    vt.push_back('{337,  1'b1, 1'b1, pk(0, 0, 20'h0,   0, 0, 0, 0, 1, 0)});
    vt.push_back('{338,  1'b1, 1'b1, pk(0, 0, 20'h0,   0, 0, 0, 0, 1, 1)});
    vt.push_back('{400,  1'b1, 1'b1, pk(0, 0, 20'h0,   0, 0, 0, 0, 1, 1)});
    vt.push_back('{432,  1'b1, 1'b1, pk(0, 1, 20'h0,   0, 0, 0, 0, 1, 1)});
    vt.push_back('{433,  1'b1, 1'b1, pk(1, 1, 20'h1,   0, 0, 0, 0, 1, 1)});
    vt.push_back('{434,  1'b1, 1'b1, pk(0, 1, 20'h2,   1, 0, 0, 0, 1, 1)});
    vt.push_back('{565,  1'b1, 1'b1, pk(0, 1, 20'h825, 1, 2, 1, 3, 1, 1)});
    vt.push_back('{567,  1'b1, 1'b1, pk(0, 1, 20'h827, 1, 2, 1, 5, 1, 1)});
    vt.push_back('{570,  1'b1, 1'b1, pk(0, 0, 20'h0,   0, 0, 0, 0, 1, 1)});
    vt.push_back('{615,  1'b1, 1'b1, pk(0, 1, 20'hC27, 1, 3, 1, 5, 1, 1)});
    vt.push_back('{617,  1'b1, 1'b1, pk(0, 0, 20'h0,   1, 3, 1, 7, 1, 1)});
    vt.push_back('{922,  1'b1, 1'b1, pk(0, 1, 20'h40A, 1, 1, 0, 8, 1, 1)});
    vt.push_back('{1047, 1'b1, 1'b0, pk(0, 1, 20'hC27, 1, 3, 1, 5, 1, 1)});
    vt.push_back('{1049, 1'b1, 1'b0, pk(0, 0, 20'h0,   1, 3, 1, 7, 1, 1)});
    vt.push_back('{1106, 1'b1, 1'b0, pk(0, 0, 20'h0,   0, 0, 0, 0, 1, 0)});
    vt.push_back('{1296, 1'b1, 1'b0, pk(0, 0, 20'h0,   0, 0, 0, 0, 1, 1)});
    vt.push_back('{1297, 1'b1, 1'b0, pk(1, 0, 20'h0,   0, 0, 0, 0, 1, 1)});
    vt.push_back('{1298, 1'b1, 1'b0, pk(0, 0, 20'h0,   0, 0, 0, 0, 1, 1)});
    vt.push_back('{1431, 1'b1, 1'b0, pk(0, 0, 20'h0,   0, 0, 0, 0, 1, 1)});

    en = 1'b1; frame_valid = 1'b0;
    do_reset();
    foreach (vt[i]) begin
      en = vt[i].en;
      frame_valid = vt[i].fv;
      while (cyc < vt[i].cyc) step();
      chk($sformatf("vec%0d_cyc%0d", i, vt[i].cyc), pk1(), vt[i].exp);
    end

    // Latency 1 vs 3 from a frame_valid already high at reset release.
    en = 1'b1; frame_valid = 1'b1;
    do_reset();
    first_rd = -1; fde1 = -1; fde3 = -1;
    for (int c = 1; c <= 1006; c++) begin
      step();
      if (first_rd < 0 && rd_en1) first_rd = cyc;
      if (fde1 < 0 && de1) fde1 = cyc;
      if (fde3 < 0 && de3) fde3 = cyc;
      if (cyc == 537) chk("lat3_pix_5_2", {de3, r3, g3, b3}, {1'b1, 5'd2, 5'd0, 5'd5});
      if (cyc == 569) chk("lat3_pix_37_2", {de3, r3, g3, b3}, {1'b1, 5'd2, 5'd1, 5'd5});
    end
    chk("first_rd_cycle", first_rd, 432);
    chk("de_lag_lat1", fde1 - first_rd, 2);
    chk("de_lag_lat3", fde3 - first_rd, 4);
    chk("hsync_before_midframe_reset", hs1, 0);

    // Mid-frame asynchronous reset, then restart on first en tick.
    rst = 1'b0;
    #1;
    chk("midframe_reset_dut1", pk1(), rst_pk);
    chk("midframe_reset_dut3", pk3(), rst_pk);
    @(posedge clk);
    #1;
    rst = 1'b1; en = 1'b0; cyc = 0;
    fs_bad = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      fs_bad += int'(fs1) + int'(fs3);
    end
    chk("no_fs_while_en_low", fs_bad, 0);
    en = 1'b1;
    step();
    chk("fs_after_first_en", {fs1, fs3, rd_en1}, 3'b110);

    // Pixel tick every other clock: line doubles, pins hold on idle clocks.
    en = 1'b1; frame_valid = 1'b0;
    do_reset();
    fall1 = -1; fall2 = -1; mism = 0; prev = 1'b1;
    for (int c = 1; c <= 300; c++) begin
      step();
      en = (cyc % 2 == 0);
      if (cyc >= 2) begin
        int k;
        logic hs_exp;
        k = (cyc - 2) / 2;
        hs_exp = !((k % 48) >= 42 && (k % 48) <= 45);
        if (hs1 !== hs_exp || de1 !== 1'b0) mism++;
      end
      if (prev && !hs1) begin
        if (fall1 < 0) fall1 = cyc;
        else if (fall2 < 0) fall2 = cyc;
      end
      prev = hs1;
    end
    chk("entoggle_first_fall", fall1, 86);
    chk("entoggle_line_length", fall2 - fall1, 96);
    chk("entoggle_hold_pattern", mism, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
